// File: rtl/instruction_encode.sv
// Packs decoded instruction fields into 19-bit words and writes them sequentially to instruction memory.
// Latency 2 cycles from accept to mem_we on an empty FIFO; in_ready drops only when the word FIFO is full.
module instruction_encode #(
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_opcode,
  input  logic [3:0]        in_func,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  input  logic [3:0]        in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [18:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [7:0]        err_count,
  output logic [ADDR_W:0]   words_written
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [18:0]       r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [18:0]       r_mem_wdata;
  logic              r_mem_we;
  logic              r_illegal;
  logic [7:0]        r_err;
  logic [ADDR_W:0]   r_ww;

  logic [18:0] w_word;
  logic        w_legal;
  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;

  // Field packing: [18:15] func, [14:11] rs2/imm, [10:7] rs1, [6:3] rd/addr, [2:0] opcode
  always_comb begin
    w_word  = '0;
    w_legal = 1'b1;
    case (in_opcode)
      3'b001: w_word = {in_func, in_rs2, in_rs1, in_rd, in_opcode};
      3'b010: w_word = {in_func, in_imm, in_rs1,
                        ((in_func == 4'h0) || (in_func == 4'hF)) ? in_rs1 : in_rd, in_opcode};
      3'b011: begin
        w_legal = (in_func[3:1] == 3'b000);
        w_word  = {in_func, 4'h0, in_func[0] ? in_rd : in_rs1, in_imm, in_opcode};
      end
      3'b100: begin
        w_legal = (in_func[3:1] == 3'b000);
        w_word  = {in_func, in_rs2, in_rs1, in_imm, in_opcode};
      end
      3'b101: w_word = {in_func, in_imm, 8'h00, in_opcode};
      3'b110: w_word = {in_func, 4'h0, in_rs1, in_imm, in_opcode};
      default: w_legal = 1'b0;
    endcase
  end

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign in_ready = (r_state == S_RUN) && !w_full;
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_legal;
  assign w_pop    = ((r_state == S_RUN) || (r_state == S_DRAIN)) && !w_empty;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_accept && in_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_empty) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Storage needs no reset: reset empties the FIFO through the pointers and count
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_next_addr <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_illegal   <= 1'b0;
      r_err       <= '0;
      r_ww        <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mem_we  <= w_pop;
      r_illegal <= w_accept && !w_legal;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_mem_wdata <= r_fifo[r_rd_ptr];
        r_mem_addr  <= r_next_addr;
        r_next_addr <= r_next_addr + 1'b1;
        if (r_ww != '1) r_ww <= r_ww + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_accept && !w_legal && (r_err != 8'hFF)) r_err <= r_err + 1'b1;
      if ((r_state == S_IDLE) && start) begin
        r_next_addr <= base_addr;
        r_err       <= '0;
        r_ww        <= '0;
      end
    end
  end

  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);
  assign illegal       = r_illegal;
  assign err_count     = r_err;
  assign words_written = r_ww;

endmodule

// File: tb/tb_instruction_encode.sv
// Randomized and directed bench for instruction_encode with a cycle-level reference model and scoreboard.
module tb_instruction_encode;
  localparam int AW = 4;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_ready, in_last;
  logic [AW-1:0] base_addr;
  logic [2:0]    in_opcode;
  logic [3:0]    in_func, in_rd, in_rs1, in_rs2, in_imm;
  logic          mem_we, busy, done, illegal;
  logic [AW-1:0] mem_addr;
  logic [18:0]   mem_wdata;
  logic [7:0]    err_count;
  logic [AW:0]   words_written;

  always #5 clk = ~clk;

  instruction_encode #(.ADDR_W(AW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_opcode(in_opcode), .in_func(in_func), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .illegal(illegal),
    .err_count(err_count), .words_written(words_written)
  );

  typedef struct {
    int op; int func; int rd; int rs1; int rs2; int imm;
  } bnd_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expired(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Word value straight from the field-placement rules
  function automatic int ref_word(input int op, input int func, input int rd, input int rs1,
                                  input int rs2, input int imm, output bit legal);
    int f2, f1, f0;
    f2 = 0; f1 = 0; f0 = 0; legal = 1'b1;
    case (op)
      1: begin f2 = rs2; f1 = rs1; f0 = rd; end
      2: begin f2 = imm; f1 = rs1; f0 = (func == 0 || func == 15) ? rs1 : rd; end
      3: begin legal = (func < 2); f1 = (func == 1) ? rd : rs1; f0 = imm; end
      4: begin legal = (func < 2); f2 = rs2; f1 = rs1; f0 = imm; end
      5: f2 = imm;
      6: begin f1 = rs1; f0 = imm; end
      default: legal = 1'b0;
    endcase
    return func * 32768 + f2 * 2048 + f1 * 128 + f0 * 8 + op;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: values below describe the current cycle
  bit m_run = 0, m_drain = 0, m_busy = 0, m_done = 0, m_we = 0, m_ill = 0;
  int m_err = 0, m_ww = 0, m_next_addr = 0, m_waddr = 0, n_push = 0, n_pop = 0;
  int q[$];
  int log_addr[$], log_data[$], log_cyc[$];
  int done_cnt = 0, ill_cnt = 0, stall_cnt = 0;
  int cp_occ, cp_w, cp_exp;
  bit cp_rdy, cp_busy, cp_nxt_done, cp_legal;

  always @(negedge clk) begin
    chk("mem_we", mem_we, m_we);
    if (m_we) begin
      cp_exp = q.pop_front();
      chk("mem_wdata", mem_wdata, cp_exp);
      chk("mem_addr", mem_addr, m_waddr);
    end
    if (mem_we === 1'b1) begin
      log_addr.push_back(int'(mem_addr));
      log_data.push_back(int'(mem_wdata));
      log_cyc.push_back(cyc);
    end
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("illegal", illegal, m_ill);
    chk("err_count", err_count, m_err);
    chk("words_written", words_written, m_ww);
    cp_occ = n_push - n_pop;
    cp_rdy = m_run && (cp_occ < D);
    chk("in_ready", in_ready, cp_rdy);
    if (done === 1'b1) done_cnt++;
    if (illegal === 1'b1) ill_cnt++;
    if (in_valid === 1'b1 && in_ready !== 1'b1) stall_cnt++;

    if (reset) begin
      m_run = 0; m_drain = 0; m_busy = 0; m_done = 0; m_we = 0; m_ill = 0;
      m_err = 0; m_ww = 0; m_next_addr = 0; n_push = 0; n_pop = 0;
      q.delete();
    end else begin
      cp_busy     = m_busy;
      cp_nxt_done = m_drain && (cp_occ == 0);
      m_we        = (m_run || m_drain) && (cp_occ > 0);
      if (m_we) begin
        n_pop++;
        m_waddr     = m_next_addr;
        m_next_addr = (m_next_addr + 1) % (1 << AW);
        if (m_ww < (1 << (AW + 1)) - 1) m_ww++;
      end
      m_ill = 0;
      if (in_valid && cp_rdy) begin
        cp_w = ref_word(in_opcode, in_func, in_rd, in_rs1, in_rs2, in_imm, cp_legal);
        if (cp_legal) begin
          q.push_back(cp_w);
          n_push++;
        end else begin
          m_ill = 1;
          if (m_err < 255) m_err++;
        end
        if (in_last) begin m_run = 0; m_drain = 1; end
      end
      if (cp_nxt_done) m_drain = 0;
      if (m_done) m_busy = 0;
      m_done = cp_nxt_done;
      if (!cp_busy && start) begin
        m_run = 1; m_busy = 1; m_err = 0; m_ww = 0;
        m_next_addr = int'(base_addr); n_push = 0; n_pop = 0;
      end
    end
  end

  // Stimulus helpers, all entered and left at posedge+1
  task automatic do_start(input int b);
    start = 1'b1; base_addr = AW'(b);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input bnd_t b, input bit last);
    bit got, ok;
    in_valid = 1'b1; in_last = last;
    in_opcode = 3'(b.op); in_func = 4'(b.func); in_rd = 4'(b.rd);
    in_rs1 = 4'(b.rs1); in_rs2 = 4'(b.rs2); in_imm = 4'(b.imm);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk); got = in_ready;
      @(posedge clk); #1;
      if (got) ok = 1'b1;
    end
    if (!ok) expired("accept_timeout");
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(posedge clk); #1;
      if (busy === 1'b0) ok = 1'b1;
    end
    if (!ok) expired("idle_timeout");
  endtask

  function automatic bnd_t mk(input int op, input int func, input int rd, input int rs1,
                              input int rs2, input int imm);
    bnd_t b;
    b.op = op; b.func = func; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.imm = imm;
    return b;
  endfunction

  function automatic bnd_t rnd(input bit legal_only);
    bnd_t b;
    int ops[4] = '{1, 2, 5, 6};
    b = mk(0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 15));
    if (legal_only) begin
      if ($urandom_range(0, 2) == 0) begin
        b.op = $urandom_range(3, 4); b.func = $urandom_range(0, 1);
      end else b.op = ops[$urandom_range(0, 3)];
    end else begin
      b.op = $urandom_range(0, 7);
      if ((b.op == 3 || b.op == 4) && $urandom_range(0, 3) != 0) b.func = $urandom_range(0, 1);
    end
    return b;
  endfunction

  int n0, d0, i0, s0, acc_cyc;

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    in_opcode = '0; in_func = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_mem_we", mem_we, 0);   chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);       chk("rst_illegal", illegal, 0);
    chk("rst_err", err_count, 0);   chk("rst_ww", words_written, 0);
    chk("rst_ready", in_ready, 0);

    // Single R word at base 3
    n0 = log_addr.size(); d0 = done_cnt;
    do_start(3);
    send(mk(1, 3, 1, 2, 5, 0), 1'b1);
    acc_cyc = cyc;
    wait_idle();
    chk("t1_nwrites", log_addr.size() - n0, 1);
    if (log_addr.size() > n0) begin
      chk("t1_addr", log_addr[n0], 3);
      chk("t1_data", log_data[n0], 32'h1A909);
      chk("t1_latency", log_cyc[n0] - acc_cyc, 1);
    end
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk("t1_words", words_written, 1);

    // J, B bne, S load from base 0
    n0 = log_addr.size();
    do_start(0);
    send(mk(5, 0, 0, 0, 0, 10), 1'b0);
    send(mk(4, 1, 0, 4, 3, 7), 1'b0);
    send(mk(3, 1, 6, 0, 0, 9), 1'b1);
    wait_idle();
    chk("t2_nwrites", log_addr.size() - n0, 3);
    if (log_addr.size() >= n0 + 3) begin
      chk("t2_a0", log_addr[n0], 0);     chk("t2_d0", log_data[n0], 32'h5005);
      chk("t2_a1", log_addr[n0 + 1], 1); chk("t2_d1", log_data[n0 + 1], 32'h9A3C);
      chk("t2_a2", log_addr[n0 + 2], 2); chk("t2_d2", log_data[n0 + 2], 32'h834B);
    end

    // Two illegal bundles then one R
    n0 = log_addr.size(); i0 = ill_cnt;
    do_start(5);
    send(mk(7, 0, 1, 1, 1, 1), 1'b0);
    send(mk(3, 5, 1, 1, 1, 1), 1'b0);
    send(mk(1, 3, 1, 2, 5, 0), 1'b1);
    wait_idle();
    chk("t3_nwrites", log_addr.size() - n0, 1);
    if (log_addr.size() > n0) chk("t3_addr", log_addr[n0], 5);
    chk("t3_illegal_pulses", ill_cnt - i0, 2);
    chk("t3_err", err_count, 2);

    // Address wrap from base 14
    n0 = log_addr.size();
    do_start(14);
    for (int k = 0; k < 4; k++) send(rnd(1'b1), k == 3);
    wait_idle();
    chk("t4_nwrites", log_addr.size() - n0, 4);
    if (log_addr.size() >= n0 + 4) begin
      chk("t4_a0", log_addr[n0], 14);    chk("t4_a1", log_addr[n0 + 1], 15);
      chk("t4_a2", log_addr[n0 + 2], 0); chk("t4_a3", log_addr[n0 + 3], 1);
    end

    // Eight back-to-back bundles
    n0 = log_addr.size(); s0 = stall_cnt;
    do_start(0);
    for (int k = 0; k < 8; k++) send(rnd(1'b1), k == 7);
    wait_idle();
    chk("t5_stalls", stall_cnt - s0, 0);
    chk("t5_nwrites", log_addr.size() - n0, 8);
    if (log_addr.size() >= n0 + 8)
      for (int k = 0; k < 7; k++) chk("t5_consecutive", log_cyc[n0 + k + 1] - log_cyc[n0 + k], 1);

    // Reset in the middle of a program
    do_start(2);
    for (int k = 0; k < 3; k++) send(rnd(1'b1), 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n0 = log_addr.size();
    chk("t6_mem_we", mem_we, 0); chk("t6_busy", busy, 0);
    chk("t6_ww", words_written, 0); chk("t6_ready", in_ready, 0);
    repeat (5) @(posedge clk);
    #1 chk("t6_no_writes", log_addr.size() - n0, 0);
    do_start(9);
    send(mk(1, 3, 1, 2, 5, 0), 1'b1);
    wait_idle();
    chk("t6_restart_nwrites", log_addr.size() - n0, 1);
    if (log_addr.size() > n0) begin
      chk("t6_restart_addr", log_addr[n0], 9);
      chk("t6_restart_data", log_data[n0], 32'h1A909);
    end

    // Random programs with gaps, illegal mixes and counter saturation
    for (int p = 0; p < 12; p++) begin
      int len;
      len = $urandom_range(1, 40);
      do_start($urandom_range(0, 15));
      for (int k = 0; k < len; k++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send(rnd(1'b0), k == len - 1);
      end
      wait_idle();
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
